// File: rtl/loader_tile_burst.sv
// Tile configuration loader: accepts a base address and length, then streams data
// beats to the selected element as registered one-hot write strobes.
//
// state | meaning
// IDLE  | waiting for a selected command
// LOAD  | accepting data beats, one write per accepted beat
// FIN   | last write strobe is out, DONE pulses
module loader_tile_burst #(
  parameter  int ADD_S   = 10,
  parameter  int DATA_S  = 8,
  parameter  int NB_E    = 2,
  parameter  int LEN_S   = 8,
  localparam int ELEM_S  = (NB_E > 1) ? $clog2(NB_E) : 1,
  localparam int LOCAL_S = ADD_S - ELEM_S
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               SELECT,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [ADD_S-1:0]   ADDRESS,
  input  logic [LEN_S-1:0]   LENGTH,
  input  logic               DATA_VALID,
  output logic               DATA_READY,
  input  logic [DATA_S-1:0]  DATA_IN,
  output logic [LOCAL_S-1:0] ADDRESS_SB_OR_CLUSTER,
  output logic [NB_E-1:0]    SELECT_SB_OR_CLUSTER,
  output logic [DATA_S-1:0]  DATA_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  input  logic               ERR_CLR
);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  localparam logic [ELEM_S:0] NB_E_W = (ELEM_S+1)'(NB_E);

  state_t             state_q, state_d;
  logic [ELEM_S-1:0]  elem_q;
  logic [LOCAL_S-1:0] local_q;
  logic [LEN_S:0]     beats_q;
  logic [NB_E-1:0]    sel_q;
  logic [LOCAL_S-1:0] addr_q;
  logic [DATA_S-1:0]  data_q;
  logic               err_q;

  logic [ELEM_S-1:0]  cmd_elem;
  logic               cmd_take, cmd_bad, cmd_ok;
  logic               beat_take, last_beat, wrap_err;
  logic [NB_E-1:0]    elem_onehot;

  assign cmd_elem  = ADDRESS[ADD_S-1:LOCAL_S];
  assign cmd_take  = (state_q == IDLE) && CMD_VALID && SELECT;
  assign cmd_bad   = cmd_take && ({1'b0, cmd_elem} >= NB_E_W);
  assign cmd_ok    = cmd_take && !cmd_bad;
  assign beat_take = (state_q == LOAD) && DATA_VALID;
  assign last_beat = (beats_q == (LEN_S+1)'(1));
  // Wrapping inside the element is only an error if more beats still follow.
  assign wrap_err  = beat_take && !last_beat && (&local_q);

  always_comb begin
    elem_onehot = '0;
    for (int i = 0; i < NB_E; i++) begin
      elem_onehot[i] = (elem_q == ELEM_S'(i));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    CMD_READY  = 1'b0;
    DATA_READY = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state_q)
      IDLE: begin
        CMD_READY = 1'b1;
        if (cmd_ok) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        DATA_READY = 1'b1;
        BUSY       = 1'b1;
        if (beat_take && last_beat) begin
          state_d = FIN;
        end
      end
      FIN: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      elem_q  <= '0;
      local_q <= '0;
      beats_q <= '0;
    end else if (cmd_ok) begin
      elem_q  <= cmd_elem;
      local_q <= ADDRESS[LOCAL_S-1:0];
      beats_q <= {1'b0, LENGTH} + (LEN_S+1)'(1);
    end else if (beat_take) begin
      local_q <= local_q + LOCAL_S'(1);
      beats_q <= beats_q - (LEN_S+1)'(1);
    end
  end

  // Write port: strobe for exactly one cycle per beat, address/data hold otherwise.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      sel_q <= '0;
      if (beat_take) begin
        sel_q  <= elem_onehot;
        addr_q <= local_q;
        data_q <= DATA_IN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (cmd_bad || wrap_err) begin
      err_q <= 1'b1;
    end else if (ERR_CLR) begin
      err_q <= 1'b0;
    end
  end

  assign SELECT_SB_OR_CLUSTER  = sel_q;
  assign ADDRESS_SB_OR_CLUSTER = addr_q;
  assign DATA_OUT              = data_q;
  assign ERR                   = err_q;

endmodule
